iter_muldiv: RTL and testbench
==============================

# iter_muldiv

Multi-cycle iterative multiply/divide unit for the multi-cycle ARM core. It replaces the single-cycle combinational long-multiply path in the ALU with a parametrised radix-2 engine. The engine covers MUL, MLA, UMULL, SMULL, UMLAL, SMLAL, UDIV and SDIV. The controller launches an operation with `start`, holds its FSM while `busy` is high, and writes `result_lo`/`result_hi` back (Rd / Ra) when `done` is high.

## Interface
- WIDTH, 32: operand width; results are WIDTH (lo) and WIDTH (hi).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; honoured only in IDLE or DONE.
- op  in  3  operation: 000 MUL, 001 MLA, 010 UMULL, 011 SMULL, 100 UMLAL, 101 SMLAL, 110 UDIV, 111 SDIV.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- acc_lo  in  WIDTH  accumulate low (MLA, xMLAL).
- acc_hi  in  WIDTH  accumulate high (xMLAL only).
- busy  out  1  high in PREP, CALC, FIX.
- done  out  1  one-cycle pulse in DONE.
- result_lo  out  WIDTH  product low / quotient.
- result_hi  out  WIDTH  product high / remainder; 0 for MUL/MLA.
- flag_n  out  1  MSB of result_hi for long ops, otherwise MSB of result_lo.
- flag_z  out  1  long ops: whole 2·WIDTH result is zero; otherwise result_lo is zero.
- div_zero  out  1  set when a divide had b == 0.

## Operation
- **Reset.** All outputs, registers and the iteration counter clear to 0; the state becomes IDLE. Reset is asynchronous, so asserting it mid-operation aborts immediately with no partial writeback.
- **Launch.** With start=1 in IDLE or DONE, op, a, b, acc_lo and acc_hi are latched on the edge and the state moves to PREP. start in PREP, CALC or FIX is ignored.
- **PREP** (1 cycle). For signed ops (SMULL, SMLAL, SDIV), latch the operand signs and replace the operands with their magnitudes. Clear the partial product / remainder. Set count to 0.
- **CALC** (exactly WIDTH cycles).
  - Multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
  - Increment count each cycle; when count == WIDTH−1, move to FIX.
- **FIX** (1 cycle).
  - Signed multiply: negate the 2·WIDTH product if sign_a ^ sign_b.
  - Accumulate: MLA adds acc_lo modulo 2^WIDTH. UMLAL/SMLAL add {acc_hi,acc_lo} modulo 2^(2·WIDTH).
  - SDIV signs: the quotient takes sign_a ^ sign_b; the remainder takes sign_a.
  - Load the result registers, flags and div_zero, then move to DONE.
- **DONE** (1 cycle). done=1, busy=0. Next state is PREP if start=1, otherwise IDLE.
- **Result hold.** Results and flags hold until the next FIX; they are not cleared on launch.
- **Divide by zero.** Full latency is kept. Result is quotient=0, remainder=a (original, signed value), div_zero=1.
- **SDIV overflow.** For a = most negative value and b = −1: quotient = most negative value, remainder = 0, div_zero=0.
- MUL/MLA ignore result_hi; it is written as 0.

## Timing
- Let edge 0 be the edge that samples start. Then:
  - edge 1 → CALC
  - edge WIDTH+1 → FIX
  - edge WIDTH+2 → DONE (done high for one cycle)
  - edge WIDTH+3 → IDLE, or PREP if start was sampled again.
- Latency is fixed at WIDTH+2 edges for every op, including divide by zero.
- Back-to-back throughput: one op per WIDTH+3 cycles.
- busy rises after edge 0 and falls after edge WIDTH+2.
- Outputs come straight from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`: op encodings (OP_MUL … OP_SDIV) and the state encoding (IDLE, PREP, CALC, FIX, DONE).
- Sub-module `muldiv_step`: combinational single-iteration step, with mode select mul/div. Inputs: accumulator/remainder, operand bit, divisor/multiplicand. Output: next accumulator and quotient bit.
- Top level holds the FSM, counter (clog2(WIDTH) bits), sign latches and FIX arithmetic.

## Test plan
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly at edge 34; busy high for 34 cycles.
- SMULL a=0xFFFFFFFE (−2), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, flag_n=1, flag_z=0.
- MLA a=5, b=7, acc_lo=100 → lo=0x87, hi=0. Then UMLAL a=1, b=1, acc={0x0,0xFFFFFFFF} → hi=1, lo=0.
- SDIV a=−7, b=2 → q=0xFFFFFFFD, rem=0xFFFFFFFF. UDIV a=7, b=0 → q=0, rem=7, div_zero=1, same latency.
- SDIV a=0x80000000, b=0xFFFFFFFF → q=0x80000000, rem=0, flag_n=1, div_zero=0.
- Pulse start during CALC → ignored, original result unchanged. Assert reset at count=10 → busy=0 and outputs 0 immediately. After release, a fresh MUL 3×4 gives lo=12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e    : 3-bit operation encoding presented on the op port
//   - state_e : controller state encoding
//   - small decode helpers used by the top level
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL   = 3'b000,
      OP_MLA   = 3'b001,
      OP_UMULL = 3'b010,
      OP_SMULL = 3'b011,
      OP_UMLAL = 3'b100,
      OP_SMLAL = 3'b101,
      OP_UDIV  = 3'b110,
      OP_SDIV  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_e;

   // Operations whose result is the full double-width value.
   function automatic logic op_is_long(op_e op);
      return (op == OP_UMULL) || (op == OP_SMULL) ||
             (op == OP_UMLAL) || (op == OP_SMLAL);
   endfunction

   function automatic logic op_is_div(op_e op);
      return (op == OP_UDIV) || (op == OP_SDIV);
   endfunction

   function automatic logic op_is_signed(op_e op);
      return (op == OP_SMULL) || (op == OP_SMLAL) || (op == OP_SDIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Combinational single iteration of the radix-2 engine.
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc      : 2*WIDTH working register
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend bits / quotient}
//   op_bit   : multiplier bit (mul, LSB of acc) or next dividend bit (div)
//   operand  : multiplicand (mul) or divisor (div), already as magnitudes
//   acc_next : next working register; in divide mode bit 0 is left clear
//              and the new quotient bit is delivered separately on q_bit
//   q_bit    : quotient bit produced by this step (0 in multiply mode)
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 div_mode,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic                 op_bit,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 q_bit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // Multiply: add the multiplicand into the upper half, keeping the carry,
      // then the whole register shifts right by one.
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_bit ? {1'b0, operand} : '0);
      // Divide: shift the next dividend bit into the partial remainder.
      rem_sh = {acc[2*WIDTH-1:WIDTH], op_bit};
      // Only meaningful when rem_sh >= operand, in which case it fits in WIDTH bits.
      diff   = rem_sh[WIDTH-1:0] - operand;

      q_bit    = 1'b0;
      acc_next = acc;
      if (div_mode) begin
         q_bit    = (rem_sh >= {1'b0, operand});
         acc_next = {(q_bit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv
// Multi-cycle radix-2 multiply/divide unit (MUL, MLA, UMULL, SMULL, UMLAL,
// SMLAL, UDIV, SDIV). Fixed latency of WIDTH+2 clock edges from start.
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0], a, b, acc_lo, acc_hi : launch request and operands
//   busy      : high in PREP, CALC, FIX
//   done      : one-cycle pulse in DONE
//   result_lo : product low / quotient
//   result_hi : product high / remainder (0 for MUL/MLA)
//   flag_n, flag_z : sign / zero of the result (double width for long ops)
//   div_zero  : last divide had a zero divisor
module iter_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] acc_hi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_n,
   output logic             flag_z,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_reg, state_next;
   op_e                op_reg;
   logic [WIDTH-1:0]   a_reg, b_reg, acc_lo_reg, acc_hi_reg;
   logic [WIDTH-1:0]   opnd_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CW-1:0]      count_reg;
   logic               sign_a, sign_b;

   logic               is_div, is_long, is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               step_bit, step_q;
   logic [2*WIDTH-1:0] step_acc;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;
   logic [WIDTH-1:0]   fix_lo, fix_hi;
   logic               fix_n, fix_z, fix_dz;

   assign is_div    = op_is_div(op_reg);
   assign is_long   = op_is_long(op_reg);
   assign is_signed = op_is_signed(op_reg);

   // Operand magnitudes; the most negative value maps onto itself, which is
   // the correct unsigned magnitude.
   assign mag_a = (is_signed && a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
   assign mag_b = (is_signed && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;

   // Multiply consumes multiplier bits from the bottom; divide consumes
   // dividend bits from the top of the low half.
   assign step_bit = is_div ? acc_reg[WIDTH-1] : acc_reg[0];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div),
      .acc      (acc_reg),
      .op_bit   (step_bit),
      .operand  (opnd_reg),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = PREP;
         PREP:    state_next = CALC;
         CALC:    if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = start ? PREP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FIX arithmetic ----------------
   always_comb begin
      // Sign latches are only ever set for signed ops.
      prod = (sign_a ^ sign_b) ? (~acc_reg + 1'b1) : acc_reg;
      quot = (sign_a ^ sign_b) ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
      rem  = sign_a ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];

      fix_lo = '0;
      fix_hi = '0;
      fix_dz = 1'b0;
      case (op_reg)
         OP_MUL:             fix_lo = prod[WIDTH-1:0];
         OP_MLA:             fix_lo = prod[WIDTH-1:0] + acc_lo_reg;
         OP_UMULL, OP_SMULL: {fix_hi, fix_lo} = prod;
         OP_UMLAL, OP_SMLAL: {fix_hi, fix_lo} = prod + {acc_hi_reg, acc_lo_reg};
         default: begin
            // A zero divisor magnitude means b was zero; report the original
            // dividend as remainder.
            if (opnd_reg == '0) begin
               fix_hi = a_reg;
               fix_dz = 1'b1;
            end else begin
               fix_lo = quot;
               fix_hi = rem;
            end
         end
      endcase

      fix_n = is_long ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
      fix_z = is_long ? ({fix_hi, fix_lo} == '0) : (fix_lo == '0);
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         op_reg     <= OP_MUL;
         a_reg      <= '0;
         b_reg      <= '0;
         acc_lo_reg <= '0;
         acc_hi_reg <= '0;
         opnd_reg   <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result_lo  <= '0;
         result_hi  <= '0;
         flag_n     <= 1'b0;
         flag_z     <= 1'b0;
         div_zero   <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy      <= (state_next == PREP) || (state_next == CALC) || (state_next == FIX);
         done      <= (state_next == DONE);

         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  op_reg     <= op_e'(op);
                  a_reg      <= a;
                  b_reg      <= b;
                  acc_lo_reg <= acc_lo;
                  acc_hi_reg <= acc_hi;
               end
            end
            PREP: begin
               sign_a    <= is_signed & a_reg[WIDTH-1];
               sign_b    <= is_signed & b_reg[WIDTH-1];
               opnd_reg  <= is_div ? mag_b : mag_a;
               acc_reg   <= {{WIDTH{1'b0}}, (is_div ? mag_b_or_a(1'b1) : mag_b_or_a(1'b0))};
               count_reg <= '0;
            end
            CALC: begin
               acc_reg   <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
               count_reg <= count_reg + CW'(1);
            end
            FIX: begin
               result_lo <= fix_lo;
               result_hi <= fix_hi;
               flag_n    <= fix_n;
               flag_z    <= fix_z;
               div_zero  <= fix_dz;
            end
            default: ;
         endcase
      end
   end

   // Low half of the working register at PREP: the dividend for divides,
   // the multiplier for multiplies.
   function automatic logic [WIDTH-1:0] mag_b_or_a(input logic want_a);
      return want_a ? mag_a : mag_b;
   endfunction

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv
// Directed vectors with hand-computed results; a scoreboard queue is filled
// at launch and drained by a monitor whenever done is seen.
module tb_iter_muldiv;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       op = 3'b000;
   logic [WIDTH-1:0] a = '0, b = '0, acc_lo = '0, acc_hi = '0;
   logic             busy, done, flag_n, flag_z, div_zero;
   logic [WIDTH-1:0] result_lo, result_hi;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic             n;
      logic             z;
      logic             dz;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   iter_muldiv #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc_lo    (acc_lo),
      .acc_hi    (acc_hi),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .div_zero  (div_zero)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h required %h", tag, act, exp_v);
      end
   endtask

   // Monitor: one comparison set per done pulse.
   always @(negedge clk) begin
      if (reset && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".lo"}, result_lo, e.lo);
            check({e.name, ".hi"}, result_hi, e.hi);
            check({e.name, ".n"},  {31'd0, flag_n}, {31'd0, e.n});
            check({e.name, ".z"},  {31'd0, flag_z}, {31'd0, e.z});
            check({e.name, ".dz"}, {31'd0, div_zero}, {31'd0, e.dz});
            $display("txn %s: lo=%h hi=%h n=%0b z=%0b dz=%0b", e.name, result_lo, result_hi,
                     flag_n, flag_z, div_zero);
         end
      end
   end

   // Launch one op, then time it; glitch_at != 0 pulses start mid-CALC.
   task automatic issue(input string name, input logic [2:0] o,
                        input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [WIDTH-1:0] ial, input logic [WIDTH-1:0] iah,
                        input logic [WIDTH-1:0] elo, input logic [WIDTH-1:0] ehi,
                        input logic en, input logic ez, input logic edz,
                        input int glitch_at);
      exp_t e;
      int   got;
      int   busy_cnt;
      e.name = name; e.lo = elo; e.hi = ehi; e.n = en; e.z = ez; e.dz = edz;
      sb_q.push_back(e);
      @(negedge clk);
      op = o; a = ia; b = ib; acc_lo = ial; acc_hi = iah; start = 1'b1;
      @(posedge clk); #1;               // edge 0
      start = 1'b0;
      // Scramble inputs so that only the latched values can produce the result.
      a = ~ia; b = ~ib; acc_lo = ~ial; acc_hi = ~iah;
      busy_cnt = busy ? 1 : 0;
      got = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (glitch_at != 0 && n == glitch_at) begin
            start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd1;
         end else if (glitch_at != 0 && n == glitch_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            got = n;
            break;
         end
         if (busy) busy_cnt++;
      end
      check({name, ".latency"}, got, WIDTH + 2);
      check({name, ".busy_cycles"}, busy_cnt, WIDTH + 2);
      check({name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.lo", result_lo, 32'd0);
      check("rst.hi", result_hi, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      issue("umull_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
            32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 0);
      issue("smull_neg", 3'b011, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
            32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
      issue("mla", 3'b001, 32'd5, 32'd7, 32'd100, 32'hDEADBEEF,
            32'h00000087, 32'h0, 1'b0, 1'b0, 1'b0, 0);
      issue("umlal_carry", 3'b100, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h0,
            32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 0);
      issue("umull_zero", 3'b010, 32'd0, 32'd5, 32'h0, 32'h0,
            32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0);
      issue("smlal", 3'b101, 32'hFFFFFFFD, 32'd5, 32'h10, 32'h0,
            32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 0);
      issue("sdiv_neg", 3'b111, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
            32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
      issue("udiv", 3'b110, 32'd100, 32'd7, 32'h0, 32'h0,
            32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 0);
      issue("udiv_zero", 3'b110, 32'd7, 32'd0, 32'h0, 32'h0,
            32'd0, 32'd7, 1'b0, 1'b1, 1'b1, 0);
      issue("sdiv_ovf", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
            32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0, 0);
      issue("mul_glitch", 3'b000, 32'h12345678, 32'h10, 32'h0, 32'h0,
            32'h23456780, 32'h0, 1'b0, 1'b0, 1'b0, 10);
      issue("sdiv_zero", 3'b111, 32'hFFFFFFF9, 32'd0, 32'h0, 32'h0,
            32'd0, 32'hFFFFFFF9, 1'b0, 1'b1, 1'b1, 0);

      // Abort mid-CALC with reset (count == 10 after edge 11).
      @(negedge clk);
      op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("abort.busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort.busy", {31'd0, busy}, 32'd0);
      check("abort.done", {31'd0, done}, 32'd0);
      check("abort.hi", result_hi, 32'd0);
      check("abort.z", {31'd0, flag_z}, 32'd0);
      check("abort.dz", {31'd0, div_zero}, 32'd0);
      $display("txn abort: busy=%0b hi=%h dz=%0b", busy, result_hi, div_zero);
      @(negedge clk);
      reset = 1'b1;

      issue("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'h0, 32'h0,
            32'd12, 32'h0, 1'b0, 1'b0, 1'b0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
